elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Car-motion controller sitting directly downstream of the hall-request decoder (updown).
- Consumes the 14-bit up/down passenger request vectors (2 slots per floor, floors 1..7) plus in-car destination requests.
- Runs a LOOK-scan state machine: moves one floor per FLOOR_CYCLES, opens the door for DOOR_CYCLES at served floors.
- Issues a one-cycle served pulse so the upstream floor queues can retire passengers.

Parameters:
- FLOOR_CYCLES, 8, clock cycles to travel one floor (>=2)
- DOOR_CYCLES, 4, clock cycles the door stays open (>=1)
- PARK_CYCLES, 32, idle cycles before parking (used only with ELEV_PARK_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- up_passenger  in  14  hall up requests; bits [2f-2], [2f-1] belong to floor f (1..7)
- down_passenger  in  14  hall down requests; same slot mapping
- car_req  in  7  in-car destination requests; bit f-1 = floor f
- cur_floor  out  3  current floor, 1..7
- dir_up  out  1  scan direction, 1=up
- moving  out  1  car between floors / travelling
- door_open  out  1  door open at cur_floor
- served  out  7  one-hot pulse (1 cycle), floor whose requests were served

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: cur_floor=1, dir_up=1, moving=0, door_open=0, served=0, state=IDLE, counters=0.
- Reset mid-operation: outputs return to reset values immediately on rst_n low, regardless of state.
- Per-floor request: req[f] = |up_passenger slots(f) | |down_passenger slots(f) | car_req[f-1], recomputed combinationally every cycle.
  - above = any req[g], g>cur_floor.
  - below = any req[g], g<cur_floor.
  - here = req[cur_floor].
- States:
  - IDLE: if here -> DOOR next cycle. Else if above -> dir_up=1, MOVE. Else if below -> dir_up=0, MOVE. Ties: here beats above, above beats below.
  - MOVE: moving=1; counter runs FLOOR_CYCLES cycles, then cur_floor +/-1 (per dir_up) and counter clears. On arrival at floor f:
    - stop (-> DOOR) if req[f], or if no requests remain ahead in dir_up;
    - else continue travelling.
  - DOOR: door_open=1, moving=0, for exactly DOOR_CYCLES cycles. served[cur_floor-1]=1 in the first DOOR cycle only. On exit:
    - requests ahead in dir_up -> MOVE;
    - else requests behind -> invert dir_up, MOVE;
    - else IDLE.
- Boundaries:
  - cur_floor never exceeds 7 or drops below 1. At floor 7 dir_up forces 0; at floor 1 it forces 1.
  - Requests are sampled live, so a request that appears ahead before arrival at its floor stops the car there. A request dropped before arrival is ignored.
  - A request at cur_floor arriving during DOOR does not extend the door; it is served on the next visit, or immediately if it is the only request left (IDLE -> DOOR).
  - Latency: IDLE with a request one floor away -> moving=1 on the next cycle; cur_floor changes FLOOR_CYCLES cycles later.

Optional Feature:
- Macro ELEV_PARK_EN.
- Defined: after PARK_CYCLES consecutive IDLE cycles with cur_floor != 1, the car moves down to floor 1 with no door opening and no served pulse. Any request during parking aborts the park and normal LOOK resumes at the next floor arrival.
- Undefined: the car stays at its last floor indefinitely; the idle counter is absent.

Decomposition:
- Package elev_pkg:
  - NUM_FLOORS=7, FLOOR_W=3;
  - state enum {IDLE, MOVE, DOOR};
  - slot-to-floor mapping function.
- One sub-module, elev_req_scan (combinational): takes the request vectors and cur_floor; produces req[7:1], above, below, here.

Test Plan:
- Reset: hold rst_n=0 mid-MOVE -> cur_floor=1, moving=0, door_open=0, served=0, dir_up=1 immediately.
- Idle at 1, up_passenger[6]=1 (floor 4) -> moving=1 next cycle; cur_floor=2,3,4 at cycles 8,16,24; door_open 4 cycles; served=7'b0001000 for one cycle; then IDLE.
- Idle at 1, car_req[0]=1 -> door_open next cycle, no movement, served=7'b0000001.
- At floor 4 going up with car_req[5] (floor 6) and down_passenger[2] (floor 2) -> serves 6, dir_up flips, serves 2, then IDLE at floor 2.
- Travelling 1->5; car_req[2] set before arrival at floor 3 -> stops at 3, served=7'b0000100, then continues to 5.
- ELEV_PARK_EN defined, IDLE at floor 5, no requests -> after 32 cycles descends to floor 1 with door_open=0 and served=0 throughout; same scenario undefined -> stays at floor 5.

Source files
------------

// File: rtl/elev_pkg.sv
// ============================================================================
// Module   : elev_pkg
// Purpose  : Shared types, floor geometry and hall-slot mapping for the
//            elevator controller slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package elev_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;
  localparam int SLOTS      = 2 * NUM_FLOORS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Hall slots 2f-2 and 2f-1 both belong to floor f.
  function automatic logic [FLOOR_W-1:0] slot_floor(input int slot);
    return FLOOR_W'(slot / 2 + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elev_req_scan.sv
// ============================================================================
// Module   : elev_req_scan
// Purpose  : Folds hall and car requests into one bit per floor and reports
//            whether any request lies above, below or at the current floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elev_req_scan
  import elev_pkg::*;
(
  input  logic [SLOTS-1:0]      up_passenger,
  input  logic [SLOTS-1:0]      down_passenger,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS:1]   req,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  logic [NUM_FLOORS:1] w_above_bits;
  logic [NUM_FLOORS:1] w_below_bits;

  always_comb begin
    req = '0;
    for (int s = 0; s < SLOTS; s++) begin
      req[slot_floor(s)] = req[slot_floor(s)] | up_passenger[s] | down_passenger[s];
    end
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      req[f] = req[f] | car_req[f-1];
    end
  end

  for (genvar f = 1; f <= NUM_FLOORS; f++) begin : g_floor
    assign w_above_bits[f] = req[f] & (FLOOR_W'(f) > cur_floor);
    assign w_below_bits[f] = req[f] & (FLOOR_W'(f) < cur_floor);
  end

  assign above = |w_above_bits;
  assign below = |w_below_bits;
  assign here  = req[cur_floor];

endmodule

`default_nettype wire

// File: rtl/elevator_ctrl.sv
// ============================================================================
// Module   : elevator_ctrl
// Purpose  : LOOK-scan car-motion controller with door timing and a one-cycle
//            served pulse. Define ELEV_PARK_EN to return an idle car to floor 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_ctrl
  import elev_pkg::*;
#(
  parameter int FLOOR_CYCLES = 8,
  parameter int DOOR_CYCLES  = 4,
  parameter int PARK_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLOTS-1:0]      up_passenger,
  input  logic [SLOTS-1:0]      down_passenger,
  input  logic [NUM_FLOORS-1:0] car_req,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] served
);

  localparam int CNT_MAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR = FLOOR_W'(1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [FLOOR_W-1:0]  r_floor, w_floor_nxt, w_arrive_floor;
  logic                r_dir_up, w_dir_nxt;
  logic [NUM_FLOORS:1] w_req;
  logic                w_above, w_below, w_here;
  logic                w_ahead, w_behind, w_arrive_ahead, w_leg_done;
  logic                w_park_start, w_park_glide;

  elev_req_scan u_scan (
    .up_passenger   (up_passenger),
    .down_passenger (down_passenger),
    .car_req        (car_req),
    .cur_floor      (r_floor),
    .req            (w_req),
    .above          (w_above),
    .below          (w_below),
    .here           (w_here)
  );

  assign w_ahead        = r_dir_up ? w_above : w_below;
  assign w_behind       = r_dir_up ? w_below : w_above;
  assign w_arrive_floor = r_dir_up ? r_floor + BOT_FLOOR : r_floor - BOT_FLOOR;
  assign w_leg_done     = (r_state == MOVE) && (r_cnt == CNT_W'(FLOOR_CYCLES - 1));

  // Requests still ahead once the car reaches the floor it is heading for.
  always_comb begin
    w_arrive_ahead = 1'b0;
    for (int g = 1; g <= NUM_FLOORS; g++) begin
      if (r_dir_up ? (FLOOR_W'(g) > w_arrive_floor) : (FLOOR_W'(g) < w_arrive_floor))
        w_arrive_ahead = w_arrive_ahead | w_req[g];
    end
  end

`ifdef ELEV_PARK_EN
  localparam int PARK_W = $clog2(PARK_CYCLES + 1);
  logic [PARK_W-1:0] r_idle_cnt;
  logic              r_park;
  logic              w_any;
  logic              w_idle_count;

  assign w_any        = |w_req;
  assign w_idle_count = (r_state == IDLE) && !w_any && (r_floor != BOT_FLOOR);
  assign w_park_start = w_idle_count && (r_idle_cnt == PARK_W'(PARK_CYCLES - 1));
  assign w_park_glide = r_park && !w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_park     <= 1'b0;
    end else begin
      r_idle_cnt <= (w_idle_count && !w_park_start) ? r_idle_cnt + PARK_W'(1) : '0;
      if (w_park_start)
        r_park <= 1'b1;
      else if (w_leg_done && !(w_park_glide && w_arrive_floor != BOT_FLOOR))
        r_park <= 1'b0;
    end
  end
`else
  // Parking compiled out: these comparisons are constant false.
  assign w_park_start = (PARK_CYCLES < 0);
  assign w_park_glide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_floor  <= BOT_FLOOR;
      r_dir_up <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_floor  <= w_floor_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir_up;
    moving      = 1'b0;
    door_open   = 1'b0;
    served      = '0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_here) begin
          w_state_nxt = DOOR;
        end else if (w_above) begin
          w_dir_nxt   = 1'b1;
          w_state_nxt = MOVE;
        end else if (w_below) begin
          w_dir_nxt   = 1'b0;
          w_state_nxt = MOVE;
        end else if (w_park_start) begin
          w_dir_nxt   = 1'b0;
          w_state_nxt = MOVE;
        end
      end
      MOVE: begin
        moving = 1'b1;
        if (w_leg_done) begin
          w_cnt_nxt   = '0;
          w_floor_nxt = w_arrive_floor;
          if (w_arrive_floor == TOP_FLOOR)
            w_dir_nxt = 1'b0;
          else if (w_arrive_floor == BOT_FLOOR)
            w_dir_nxt = 1'b1;
          if (w_park_glide)
            w_state_nxt = (w_arrive_floor == BOT_FLOOR) ? IDLE : MOVE;
          else if (w_req[w_arrive_floor] || !w_arrive_ahead)
            w_state_nxt = DOOR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DOOR: begin
        door_open = 1'b1;
        if (r_cnt == '0)
          served = NUM_FLOORS'(1) << (r_floor - BOT_FLOOR);
        if (r_cnt == CNT_W'(DOOR_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (w_ahead) begin
            w_state_nxt = MOVE;
          end else if (w_behind) begin
            w_dir_nxt   = ~r_dir_up;
            w_state_nxt = MOVE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign cur_floor = r_floor;
  assign dir_up    = r_dir_up;

endmodule

`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
// ============================================================================
// Module   : tb_elevator_ctrl
// Purpose  : Directed self-checking bench for elevator_ctrl (8/4/32 timing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] up_passenger = '0;
  logic [13:0] down_passenger = '0;
  logic [6:0]  car_req = '0;
  logic [2:0]  cur_floor;
  logic        dir_up;
  logic        moving;
  logic        door_open;
  logic [6:0]  served;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_ctrl #(
    .FLOOR_CYCLES (8),
    .DOOR_CYCLES  (4),
    .PARK_CYCLES  (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .up_passenger   (up_passenger),
    .down_passenger (down_passenger),
    .car_req        (car_req),
    .cur_floor      (cur_floor),
    .dir_up         (dir_up),
    .moving         (moving),
    .door_open      (door_open),
    .served         (served)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic door_seen;
    logic served_seen;

    // Reset values
    cyc(2);
    chk("rst_floor", cur_floor, 1);
    chk("rst_dir", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_served", served, 0);

    // Car request at the current floor: door opens without motion
    rst_n = 1'b1;
    car_req = 7'b0000001;
    cyc(1);
    chk("here_door", door_open, 1);
    chk("here_served", served, 7'b0000001);
    chk("here_moving", moving, 0);
    car_req = '0;
    cyc(3);
    chk("here_door_last", door_open, 1);
    chk("here_served_once", served, 0);
    cyc(1);
    chk("here_door_closed", door_open, 0);

    // Hall up request at floor 4 from floor 1
    up_passenger = 14'b00000001000000;
    cyc(1);
    chk("f4_moving", moving, 1);
    chk("f4_start_floor", cur_floor, 1);
    cyc(7);
    chk("f4_floor_c7", cur_floor, 1);
    cyc(1);
    chk("f4_floor_c8", cur_floor, 2);
    cyc(8);
    chk("f4_floor_c16", cur_floor, 3);
    cyc(8);
    chk("f4_floor_c24", cur_floor, 4);
    chk("f4_door", door_open, 1);
    chk("f4_served", served, 7'b0001000);
    chk("f4_stopped", moving, 0);
    up_passenger = '0;
    cyc(1);
    chk("f4_served_once", served, 0);
    cyc(3);
    chk("f4_door_closed", door_open, 0);
    chk("f4_idle", moving, 0);

    // Floor 4 going up: serve 6, reverse, serve 2
    car_req = 7'b0100000;
    down_passenger = 14'b00000000000100;
    cyc(1);
    chk("rev_moving", moving, 1);
    chk("rev_dir_up", dir_up, 1);
    cyc(16);
    chk("rev_f6_floor", cur_floor, 6);
    chk("rev_f6_served", served, 7'b0100000);
    car_req = '0;
    cyc(4);
    chk("rev_leave_moving", moving, 1);
    chk("rev_leave_dir", dir_up, 0);
    cyc(32);
    chk("rev_f2_floor", cur_floor, 2);
    chk("rev_f2_door", door_open, 1);
    chk("rev_f2_served", served, 7'b0000010);
    down_passenger = '0;
    cyc(4);
    chk("rev_idle_door", door_open, 0);
    chk("rev_idle_moving", moving, 0);
    chk("rev_idle_floor", cur_floor, 2);
    chk("rev_idle_dir", dir_up, 0);

    // Asynchronous reset while travelling down
    car_req = 7'b0000001;
    cyc(4);
    chk("mid_moving", moving, 1);
    chk("mid_dir", dir_up, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_floor", cur_floor, 1);
    chk("mid_rst_dir", dir_up, 1);
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_door", door_open, 0);
    chk("mid_rst_served", served, 0);
    car_req = '0;
    cyc(1);
    rst_n = 1'b1;

    // Travelling 1->5, floor 3 requested en route
    car_req = 7'b0010000;
    cyc(1);
    chk("en_moving", moving, 1);
    cyc(9);
    chk("en_floor2", cur_floor, 2);
    car_req = 7'b0010100;
    cyc(7);
    chk("en_f3_floor", cur_floor, 3);
    chk("en_f3_door", door_open, 1);
    chk("en_f3_served", served, 7'b0000100);
    car_req = 7'b0010000;
    cyc(4);
    chk("en_resume", moving, 1);
    cyc(16);
    chk("en_f5_floor", cur_floor, 5);
    chk("en_f5_served", served, 7'b0010000);
    car_req = '0;
    cyc(4);
    chk("en_f5_closed", door_open, 0);

    // Long idle at floor 5
    door_seen = 1'b0;
    served_seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      cyc(1);
      door_seen = door_seen | door_open;
      served_seen = served_seen | (served != '0);
    end
    chk("idle_no_door", door_seen, 0);
    chk("idle_no_served", served_seen, 0);
    chk("idle_moving", moving, 0);
`ifdef ELEV_PARK_EN
    chk("idle_park_floor", cur_floor, 1);
`else
    chk("idle_stay_floor", cur_floor, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
